ad_bus_sequencer: RTL and testbench
===================================

Name: ad_bus_sequencer

Overview:
- Bus-cycle sequencer that sits directly upstream of the address/data switch (SWITCH_A_D) on the multiplexed AD bus.
- Accepts one read or write request at a time and splits it into timed phases: address phase, turnaround, data phase, recovery.
- Drives the switch's phase selects `adr`/`dat`, the AD output word, the output enable and the ALE/RD/WR strobes.
- Returns read data and a completion pulse to the requester.

Parameters:
- W, 8, width of address, data and the multiplexed AD bus.
- ADR_CYC, 2, address-phase length in clocks; legal range 1..15.
- DAT_CYC, 3, data-phase length in clocks; legal range 1..15.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- req  in  1  request strobe; sampled only while busy=0.
- we  in  1  1=write, 0=read; captured with req.
- addr  in  W  bus address; captured with req.
- wdata  in  W  write data; captured with req.
- busy  out  1  high from the cycle after acceptance until the cycle after done.
- done  out  1  one-cycle completion pulse.
- rdata  out  W  read data; valid while done=1 for a read, held until the next read completes.
- adr  out  1  address-phase select to the switch.
- dat  out  1  data-phase select to the switch.
- ale  out  1  address latch enable.
- ad_out  out  W  word driven onto the AD bus.
- ad_oe  out  1  AD output enable.
- ad_in  in  W  AD bus sampled value.
- rd_n  out  1  active-low read strobe.
- wr_n  out  1  active-low write strobe.

Behaviour:
- Reset values: busy=0, done=0, rdata=0, adr=0, dat=0, ale=0, ad_out=0, ad_oe=0, rd_n=1, wr_n=1, state=IDLE. All outputs are registered.
- FSM states: IDLE, ADDR, TURN, DATA, RECOV. A 4-bit phase counter ph is used in ADDR and DATA.
- IDLE: if req=1 at an edge, capture addr/we/wdata, go to ADDR, set ph=ADR_CYC-1. Otherwise stay in IDLE; req is ignored whenever busy=1.
- ADDR, lasting ADR_CYC cycles:
  - adr=1, ad_oe=1, ad_out=captured addr.
  - ale=1 in the first ADDR cycle only.
  - When ph==0, go to TURN; otherwise decrement ph.
- TURN, exactly 1 cycle:
  - adr=0, dat=0, ad_oe=0, ad_out=0.
  - This is the no-contention gap before the data phase.
- DATA, lasting DAT_CYC cycles:
  - dat=1.
  - Write: ad_oe=1, ad_out=wdata, wr_n=0 for all DATA cycles.
  - Read: ad_oe=0, rd_n=0 for all DATA cycles; on the last DATA cycle (ph==0), rdata<=ad_in at that edge.
- RECOV, exactly 1 cycle:
  - done=1, all strobes inactive, adr=dat=0.
  - busy=1 during RECOV; next state IDLE with busy=0.
- Latency: acceptance edge to done = ADR_CYC+DAT_CYC+2 cycles (7 at defaults). Back-to-back issue: the earliest next acceptance is the edge after done falls, so there is at least 1 idle cycle between transactions.
- Invariants:
  - adr and dat are never both 1.
  - rd_n and wr_n are never both 0.
  - ad_oe=0 whenever rd_n=0.
  - ale=1 implies adr=1.
- Reset mid-operation: the next edge forces all reset values, the transaction is abandoned, and no done pulse is produced.
- req held high continuously: one transaction per IDLE visit; no request is queued.
- Input changes after acceptance have no effect on the transaction in flight.

Decomposition:
- Shared include/package holds the state encoding localparams (IDLE=0, ADDR=1, TURN=2, DATA=3, RECOV=4) and the 4-bit phase counter width. The switch and the testbench share these.
- Single module; no sub-module is needed. The phase counter stays inline.

Test Plan:
- Reset behaviour: rst=1 for 3 cycles with req=1 -> all outputs at reset values; no transaction starts until rst=0.
- Write, defaults: addr=8'h5A, wdata=8'hC3, we=1.
  - adr=1 with ad_out=5A for 2 cycles, ale=1 in the first of them.
  - 1 cycle with ad_oe=0.
  - dat=1, wr_n=0, ad_out=C3 for 3 cycles.
  - done at cycle 7.
- Read, defaults: addr=8'h10, we=0, ad_in=8'h7E during DATA -> rd_n=0 for 3 cycles, ad_oe=0, rdata=7E at done; rdata still 7E after done.
- Back-to-back requests with req held high (write then read) -> second acceptance one cycle after done; busy low exactly 1 cycle between them; no overlap of adr/dat.
- Reset mid-operation: rst=1 in the second DATA cycle of a write -> wr_n=1, ad_oe=0, busy=0 next cycle; done never pulses.
- Parameter corner ADR_CYC=1, DAT_CYC=1 -> adr 1 cycle with ale, TURN 1 cycle, dat 1 cycle, done at cycle 4. A checker asserts all invariants throughout.

Source files
------------

// File: rtl/ad_bus_sequencer_pkg.sv
// Shared definitions for the AD bus sequencer: bus-cycle state encoding and
// phase counter width, also used by the AD switch and the testbench.
package ad_bus_sequencer_pkg;

  localparam int PH_W = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    TURN  = 3'd2,
    DATA  = 3'd3,
    RECOV = 3'd4
  } state_e;

endpackage

// File: rtl/ad_bus_sequencer.sv
// Splits one read/write request into address, turnaround, data and recovery
// phases on the multiplexed AD bus. Every output is a flop fed from next state.
module ad_bus_sequencer
  import ad_bus_sequencer_pkg::*;
#(
  parameter int W       = 8,
  parameter int ADR_CYC = 2,
  parameter int DAT_CYC = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req,
  input  logic         we,
  input  logic [W-1:0] addr,
  input  logic [W-1:0] wdata,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] rdata,
  output logic         adr,
  output logic         dat,
  output logic         ale,
  output logic [W-1:0] ad_out,
  output logic         ad_oe,
  input  logic [W-1:0] ad_in,
  output logic         rd_n,
  output logic         wr_n
);

  state_e            state_q, state_d;
  logic [PH_W-1:0]   ph_q, ph_d;
  logic [W-1:0]      addr_q, addr_d;
  logic [W-1:0]      wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [W-1:0]      rdata_q, rdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              adr_q, adr_d;
  logic              dat_q, dat_d;
  logic              ale_q, ale_d;
  logic [W-1:0]      ad_out_q, ad_out_d;
  logic              ad_oe_q, ad_oe_d;
  logic              rd_n_q, rd_n_d;
  logic              wr_n_q, wr_n_d;

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = ADDR;
          ph_d    = PH_W'(ADR_CYC - 1);
          addr_d  = addr;
          wdata_d = wdata;
          we_d    = we;
        end
      end
      ADDR: begin
        if (ph_q == '0) state_d = TURN;
        else            ph_d    = ph_q - PH_W'(1);
      end
      TURN: begin
        state_d = DATA;
        ph_d    = PH_W'(DAT_CYC - 1);
      end
      DATA: begin
        if (ph_q == '0) begin
          state_d = RECOV;
          if (!we_q) rdata_d = ad_in;
        end else begin
          ph_d = ph_q - PH_W'(1);
        end
      end
      RECOV:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs describe the cycle about to start, so they decode the next state.
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == RECOV);
    adr_d    = (state_d == ADDR);
    dat_d    = (state_d == DATA);
    ale_d    = (state_q == IDLE) && (state_d == ADDR);
    ad_oe_d  = adr_d || (dat_d && we_d);
    ad_out_d = adr_d ? addr_d : ((dat_d && we_d) ? wdata_d : '0);
    rd_n_d   = !(dat_d && !we_d);
    wr_n_d   = !(dat_d && we_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ph_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      rdata_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      adr_q    <= 1'b0;
      dat_q    <= 1'b0;
      ale_q    <= 1'b0;
      ad_out_q <= '0;
      ad_oe_q  <= 1'b0;
      rd_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      ph_q     <= ph_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      rdata_q  <= rdata_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      ale_q    <= ale_d;
      ad_out_q <= ad_out_d;
      ad_oe_q  <= ad_oe_d;
      rd_n_q   <= rd_n_d;
      wr_n_q   <= wr_n_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign rdata  = rdata_q;
  assign adr    = adr_q;
  assign dat    = dat_q;
  assign ale    = ale_q;
  assign ad_out = ad_out_q;
  assign ad_oe  = ad_oe_q;
  assign rd_n   = rd_n_q;
  assign wr_n   = wr_n_q;

endmodule

// File: tb/tb_ad_bus_sequencer.sv
// Testbench: default-sized and minimum-phase sequencers driven in parallel,
// checked every cycle against a cycle-schedule model plus literal expectations.
module tb_ad_bus_sequencer;

  logic       clk, rst, req, we;
  logic [7:0] addr, wdata, ad_in;

  logic       busy0, done0, adr0, dat0, ale0, ad_oe0, rd_n0, wr_n0;
  logic [7:0] rdata0, ad_out0;
  logic       busy1, done1, adr1, dat1, ale1, ad_oe1, rd_n1, wr_n1;
  logic [7:0] rdata1, ad_out1;

  int tests = 0;
  int fails = 0;

  ad_bus_sequencer #(.W(8), .ADR_CYC(2), .DAT_CYC(3)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .busy(busy0), .done(done0), .rdata(rdata0), .adr(adr0), .dat(dat0),
    .ale(ale0), .ad_out(ad_out0), .ad_oe(ad_oe0), .ad_in(ad_in),
    .rd_n(rd_n0), .wr_n(wr_n0)
  );

  ad_bus_sequencer #(.W(8), .ADR_CYC(1), .DAT_CYC(1)) dut_min (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .busy(busy1), .done(done1), .rdata(rdata1), .adr(adr1), .dat(dat1),
    .ale(ale1), .ad_out(ad_out1), .ad_oe(ad_oe1), .ad_in(ad_in),
    .rd_n(rd_n1), .wr_n(wr_n1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: k = cycles since acceptance (0 = idle); phases are ranges of k.
  int         k[2];
  logic [7:0] cap_a[2], cap_w[2], rexp[2];
  logic       cap_we[2];

  function automatic int adr_len(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic int dat_len(input int i);
    return (i == 0) ? 3 : 1;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int a, d, l;
      a = adr_len(i);
      d = dat_len(i);
      l = a + d + 2;
      if (rst) begin
        k[i]    = 0;
        rexp[i] = 8'h00;
      end else if (k[i] == 0) begin
        if (req) begin
          k[i]      = 1;
          cap_a[i]  = addr;
          cap_w[i]  = wdata;
          cap_we[i] = we;
        end
      end else begin
        if (k[i] == a + 1 + d && !cap_we[i]) rexp[i] = ad_in;
        k[i] = (k[i] == l) ? 0 : k[i] + 1;
      end
    end
  end

  // {busy,done,rdata,adr,dat,ale,ad_out,ad_oe,rd_n,wr_n}
  function automatic logic [23:0] expv(input int i);
    int a, d, kk;
    logic ae, de, wrd, rdd;
    logic [7:0] oe;
    a   = adr_len(i);
    d   = dat_len(i);
    kk  = k[i];
    ae  = (kk >= 1) && (kk <= a);
    de  = (kk >= a + 2) && (kk <= a + 1 + d);
    wrd = de && cap_we[i];
    rdd = de && !cap_we[i];
    oe  = ae ? cap_a[i] : (wrd ? cap_w[i] : 8'h00);
    return {kk != 0, kk == a + d + 2, rexp[i], ae, de, kk == 1, oe, ae | wrd, !rdd, !wrd};
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [23:0] got, exp_v;
      got = (i == 0)
          ? {busy0, done0, rdata0, adr0, dat0, ale0, ad_out0, ad_oe0, rd_n0, wr_n0}
          : {busy1, done1, rdata1, adr1, dat1, ale1, ad_out1, ad_oe1, rd_n1, wr_n1};
      exp_v = expv(i);
      tests++;
      if (got !== exp_v) begin
        fails++;
        $display("FAIL model_cmp dut%0d t=%0t got=%h exp=%h", i, $time, got, exp_v);
      end
      tests++;
      if ((got[13] && got[12]) || (!got[1] && !got[0]) || (!got[1] && got[2]) ||
          (got[11] && !got[13])) begin
        fails++;
        $display("FAIL invariant dut%0d t=%0t outputs=%h", i, $time, got);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp_v);
    tests++;
    if (got !== exp_v) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", name, got, exp_v);
    end
  endtask

  int d0, d1, gap, acc2, seen, dones;

  initial begin
    rst = 1'b1; req = 1'b1; we = 1'b1;
    addr = 8'h00; wdata = 8'h00; ad_in = 8'h00;
    repeat (3) tick();
    check("rst_busy", {7'd0, busy0}, 8'h00);
    check("rst_rd_n", {7'd0, rd_n0}, 8'h01);
    check("rst_wr_n", {7'd0, wr_n0}, 8'h01);
    check("rst_ad_oe", {7'd0, ad_oe0}, 8'h00);
    rst = 1'b0; req = 1'b0;
    repeat (2) tick();
    check("idle_busy", {7'd0, busy0}, 8'h00);
    $display("[TB] reset done");

    // Write; inputs change after acceptance and must be ignored.
    req = 1'b1; we = 1'b1; addr = 8'h5A; wdata = 8'hC3;
    tick();
    req = 1'b0; addr = 8'hFF; wdata = 8'h00; we = 1'b0;
    check("wr_ale", {7'd0, ale0}, 8'h01);
    check("wr_adr", {7'd0, adr0}, 8'h01);
    check("wr_ad_out_addr", ad_out0, 8'h5A);
    d0 = 0; d1 = 0;
    for (int c = 1; c <= 12; c++) begin
      if (done0 && d0 == 0) d0 = c;
      if (done1 && d1 == 0) d1 = c;
      if (c == 2) check("wr_ale_once", {7'd0, ale0}, 8'h00);
      if (c == 3) check("wr_turn_oe", {7'd0, ad_oe0}, 8'h00);
      if (c == 4) begin
        check("wr_ad_out_data", ad_out0, 8'hC3);
        check("wr_wr_n", {7'd0, wr_n0}, 8'h00);
      end
      tick();
    end
    check("wr_latency", 8'(d0), 8'd7);
    check("wr_latency_min", 8'(d1), 8'd4);
    $display("[TB] write 5A<-C3 done at cycle %0d (min cfg %0d)", d0, d1);

    // Read with constant AD input.
    req = 1'b1; we = 1'b0; addr = 8'h10; ad_in = 8'h7E;
    tick();
    req = 1'b0;
    d0 = 0;
    for (int c = 1; c <= 12; c++) begin
      if (done0 && d0 == 0) begin
        d0 = c;
        check("rd_rdata_at_done", rdata0, 8'h7E);
      end
      if (c == 5) begin
        check("rd_rd_n", {7'd0, rd_n0}, 8'h00);
        check("rd_ad_oe", {7'd0, ad_oe0}, 8'h00);
      end
      tick();
    end
    check("rd_latency", 8'(d0), 8'd7);
    check("rd_rdata_held", rdata0, 8'h7E);
    check("rd_rdata_min", rdata1, 8'h7E);
    $display("[TB] read 10 -> %h", rdata0);

    // Read with a changing AD input: only the last data cycle is sampled.
    req = 1'b1; we = 1'b0; addr = 8'h20;
    tick();
    req = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      ad_in = 8'h30 + 8'(c);
      tick();
    end
    check("rd_last_cycle", rdata0, 8'h36);
    check("rd_last_cycle_min", rdata1, 8'h33);
    $display("[TB] read 20 -> %h (min cfg %h)", rdata0, rdata1);

    // Back-to-back with req held high.
    req = 1'b1; we = 1'b1; addr = 8'hA1; wdata = 8'hB2;
    tick();
    seen = 0; gap = 0; acc2 = 0;
    for (int c = 1; c <= 20; c++) begin
      if (c == 2) begin we = 1'b0; addr = 8'h3C; end
      if (acc2 == 0) begin
        if (done0) seen = 1;
        else if (seen != 0 && !busy0) gap++;
        else if (seen != 0 && busy0) acc2 = c;
      end
      tick();
    end
    req = 1'b0;
    repeat (12) tick();
    check("b2b_gap", 8'(gap), 8'd1);
    check("b2b_accept", 8'(acc2), 8'd9);
    $display("[TB] back-to-back gap=%0d second busy at cycle %0d", gap, acc2);

    // Reset in the second data cycle of a write.
    req = 1'b1; we = 1'b1; addr = 8'h22; wdata = 8'h44;
    tick();
    req = 1'b0;
    repeat (4) tick();
    check("mid_wr_n_before", {7'd0, wr_n0}, 8'h00);
    rst = 1'b1;
    tick();
    check("mid_busy", {7'd0, busy0}, 8'h00);
    check("mid_wr_n", {7'd0, wr_n0}, 8'h01);
    check("mid_ad_oe", {7'd0, ad_oe0}, 8'h00);
    rst = 1'b0;
    dones = 0;
    for (int c = 0; c < 10; c++) begin
      if (done0) dones++;
      tick();
    end
    check("mid_no_done", 8'(dones), 8'd0);
    $display("[TB] reset mid-write, done pulses=%0d", dones);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
